// File: rtl/vending_core_param_pkg.sv
// Shared definitions for the parametrised vending core: state encodings,
// default price/coin tables and default sizing.
package vending_param_defs;

  typedef enum logic [1:0] {
    kIdle   = 2'd0,
    kHold   = 2'd1,
    kReturn = 2'd2
  } vend_state_t;

  localparam int DEF_TOTAL_BITS = 31;
  localparam int DEF_WAIT_TIME  = 100;

  // Index 0 sits in the least significant slice.
  localparam logic [4*31-1:0] DEF_ITEM_PRICES = {31'd2000, 31'd1000, 31'd500, 31'd400};
  localparam logic [3*31-1:0] DEF_COIN_VALUES = {31'd1000, 31'd500, 31'd100};

  function automatic int cnt_bits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vending_core_param_state_reg.sv
// Register bank of the vending core: state, running total, idle counter and
// the dispense pulse, all cleared asynchronously by reset_n.
module vending_state_reg #(
  parameter int TOTAL_BITS = 31,
  parameter int N_ITEMS    = 4,
  parameter int WAIT_BITS  = 7,
  parameter int WAIT_TIME  = 100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            state_nxt,
  input  logic [TOTAL_BITS-1:0] total_nxt,
  input  logic [WAIT_BITS-1:0]  wait_nxt,
  input  logic [N_ITEMS-1:0]    item_nxt,
  output logic [1:0]            state,
  output logic [TOTAL_BITS-1:0] total,
  output logic [WAIT_BITS-1:0]  wait_cnt,
  output logic [N_ITEMS-1:0]    output_item
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= 2'd0;
      total       <= '0;
      wait_cnt    <= WAIT_BITS'(WAIT_TIME);
      output_item <= '0;
    end else begin
      state       <= state_nxt;
      total       <= total_nxt;
      wait_cnt    <= wait_nxt;
      output_item <= item_nxt;
    end
  end

endmodule

// File: rtl/vending_core_param.sv
// Parametrised vending core: coin credit, lowest-index affordable dispense,
// idle timeout and largest-coin-first change return.
module vending_core_param
  import vending_param_defs::*;
#(
  parameter int TOTAL_BITS = DEF_TOTAL_BITS,
  parameter int N_ITEMS    = 4,
  parameter int N_COINS    = 3,
  parameter logic [N_ITEMS*TOTAL_BITS-1:0] ITEM_PRICES = DEF_ITEM_PRICES,
  parameter logic [N_COINS*TOTAL_BITS-1:0] COIN_VALUES = DEF_COIN_VALUES,
  parameter int WAIT_TIME  = DEF_WAIT_TIME
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_COINS-1:0]    i_input_coin,
  input  logic [N_ITEMS-1:0]    i_select_item,
  input  logic                  i_trigger_return,
  output logic [N_ITEMS-1:0]    o_available_item,
  output logic [N_ITEMS-1:0]    o_output_item,
  output logic [N_COINS-1:0]    o_return_coin,
  output logic [TOTAL_BITS-1:0] o_current_total,
  output logic                  o_busy,
  output logic [1:0]            dbg_state
);

  localparam int WAIT_BITS = cnt_bits(WAIT_TIME);
  localparam int SUM_BITS  = TOTAL_BITS + $clog2(N_COINS + 1);
  localparam logic [TOTAL_BITS-1:0] TOTAL_MAX = '1;

  logic [1:0]            state_q, state_nxt;
  vend_state_t           state;
  logic [TOTAL_BITS-1:0] total_q, total_nxt;
  logic [WAIT_BITS-1:0]  wait_q, wait_nxt;
  logic [N_ITEMS-1:0]    item_nxt;

  logic [SUM_BITS-1:0]   coin_sum;
  logic                  pick_found;
  logic [N_ITEMS-1:0]    pick_onehot;
  logic [TOTAL_BITS-1:0] pick_price;
  logic                  ret_found;
  logic [N_COINS-1:0]    ret_onehot;
  logic [TOTAL_BITS-1:0] ret_value;

  logic                  trig_hold;
  logic                  buy_en;
  logic                  coin_ok;
  logic [TOTAL_BITS-1:0] after_buy;
  logic [SUM_BITS-1:0]   credit;
  logic [TOTAL_BITS-1:0] updated;

  assign state = vend_state_t'(state_q);

  always_comb begin
    coin_sum         = '0;
    o_available_item = '0;
    pick_found       = 1'b0;
    pick_onehot      = '0;
    pick_price       = '0;
    ret_found        = 1'b0;
    ret_onehot       = '0;
    ret_value        = '0;
    for (int i = 0; i < N_COINS; i++) begin
      if (i_input_coin[i])
        coin_sum = coin_sum + SUM_BITS'(COIN_VALUES[i*TOTAL_BITS +: TOTAL_BITS]);
      // Coins ascend by index, so the last fit is the largest one.
      if (COIN_VALUES[i*TOTAL_BITS +: TOTAL_BITS] <= total_q) begin
        ret_found     = 1'b1;
        ret_onehot    = '0;
        ret_onehot[i] = 1'b1;
        ret_value     = COIN_VALUES[i*TOTAL_BITS +: TOTAL_BITS];
      end
    end
    for (int i = 0; i < N_ITEMS; i++) begin
      o_available_item[i] = ITEM_PRICES[i*TOTAL_BITS +: TOTAL_BITS] <= total_q;
      if (!pick_found && i_select_item[i] && o_available_item[i]) begin
        pick_found     = 1'b1;
        pick_onehot[i] = 1'b1;
        pick_price     = ITEM_PRICES[i*TOTAL_BITS +: TOTAL_BITS];
      end
    end
  end

  // A return request in HOLD suppresses the purchase but still banks coins.
  assign trig_hold = (state == kHold) && i_trigger_return;
  assign buy_en    = pick_found && !trig_hold;
  assign after_buy = total_q - (buy_en ? pick_price : '0);
  assign credit    = SUM_BITS'(after_buy) + coin_sum;
  assign coin_ok   = (coin_sum != '0) && (credit <= SUM_BITS'(TOTAL_MAX));
  assign updated   = coin_ok ? credit[TOTAL_BITS-1:0] : after_buy;

  always_comb begin
    state_nxt = state_q;
    total_nxt = total_q;
    wait_nxt  = wait_q;
    item_nxt  = '0;
    if (state == kReturn) begin
      wait_nxt = WAIT_BITS'(WAIT_TIME);
      if (!ret_found || total_q == ret_value) begin
        total_nxt = '0;
        state_nxt = kIdle;
      end else begin
        total_nxt = total_q - ret_value;
      end
    end else begin
      total_nxt = updated;
      if (buy_en)
        item_nxt = pick_onehot;
      if (coin_ok || buy_en || trig_hold)
        wait_nxt = WAIT_BITS'(WAIT_TIME);
      else if (state == kHold && wait_q != '0)
        wait_nxt = wait_q - WAIT_BITS'(1);
      if (trig_hold || (state == kHold && !coin_ok && !buy_en && wait_q <= WAIT_BITS'(1)))
        state_nxt = kReturn;
      else
        state_nxt = (updated != '0) ? kHold : kIdle;
    end
  end

  vending_state_reg #(
    .TOTAL_BITS(TOTAL_BITS),
    .N_ITEMS   (N_ITEMS),
    .WAIT_BITS (WAIT_BITS),
    .WAIT_TIME (WAIT_TIME)
  ) u_state_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .state_nxt  (state_nxt),
    .total_nxt  (total_nxt),
    .wait_nxt   (wait_nxt),
    .item_nxt   (item_nxt),
    .state      (state_q),
    .total      (total_q),
    .wait_cnt   (wait_q),
    .output_item(o_output_item)
  );

  assign o_current_total = total_q;
  assign o_busy          = (state == kReturn);
  assign o_return_coin   = (state == kReturn) ? ret_onehot : '0;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_vending_core_param.sv
// Directed bench for vending_core_param: default-width instance plus an
// 11-bit total instance for the overflow-rejection cases.
module tb_vending_core_param;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic [2:0]  coin_a = '0, coin_b = '0;
  logic [3:0]  sel_a = '0, sel_b = '0;
  logic        trig_a = 1'b0, trig_b = 1'b0;

  logic [3:0]  avail_a, item_a, avail_b, item_b;
  logic [2:0]  ret_a, ret_b;
  logic [30:0] total_a;
  logic [10:0] total_b;
  logic        busy_a, busy_b;
  logic [1:0]  st_a, st_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0]  exp_q[$];
  logic [30:0] tot_q[$];

  always #5 clk = ~clk;

  vending_core_param u_dut (
    .clk(clk), .reset_n(reset_n),
    .i_input_coin(coin_a), .i_select_item(sel_a), .i_trigger_return(trig_a),
    .o_available_item(avail_a), .o_output_item(item_a), .o_return_coin(ret_a),
    .o_current_total(total_a), .o_busy(busy_a), .dbg_state(st_a)
  );

  vending_core_param #(
    .TOTAL_BITS(11),
    .ITEM_PRICES({11'd2000, 11'd1000, 11'd500, 11'd400}),
    .COIN_VALUES({11'd1000, 11'd500, 11'd100})
  ) u_dut11 (
    .clk(clk), .reset_n(reset_n),
    .i_input_coin(coin_b), .i_select_item(sel_b), .i_trigger_return(trig_b),
    .o_available_item(avail_b), .o_output_item(item_b), .o_return_coin(ret_b),
    .o_current_total(total_b), .o_busy(busy_b), .dbg_state(st_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] coin, input logic [3:0] sel, input logic trig);
    coin_a = coin; sel_a = sel; trig_a = trig;
    tick();
    coin_a = '0; sel_a = '0; trig_a = 1'b0;
  endtask

  task automatic drive_b(input logic [2:0] coin, input logic [3:0] sel);
    coin_b = coin; sel_b = sel;
    tick();
    coin_b = '0; sel_b = '0;
  endtask

  initial begin
    // reset
    #12;
    check_eq("rst_total", total_a, 0);
    check_eq("rst_state", st_a, 0);
    check_eq("rst_item", item_a, 0);
    check_eq("rst_ret", ret_a, 0);
    check_eq("rst_busy", busy_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // coins in the same cycle do not fund a purchase
    drive_a(3'b010, 4'b0001, 1'b0);
    check_eq("nofund_item", item_a, 0);
    check_eq("nofund_total", total_a, 500);
    check_eq("nofund_state", st_a, 1);
    // unaffordable selection ignored
    drive_a(3'b000, 4'b0100, 1'b0);
    check_eq("unaff_item", item_a, 0);
    check_eq("unaff_total", total_a, 500);
    // two selections: lowest index wins
    drive_a(3'b000, 4'b0011, 1'b0);
    check_eq("lowidx_item", item_a, 4'b0001);
    check_eq("lowidx_total", total_a, 100);
    tick();
    check_eq("pulse_clear", item_a, 0);
    drive_a(3'b000, 4'b0000, 1'b1);
    check_eq("ret100_busy", busy_a, 1);
    check_eq("ret100_coin", ret_a, 3'b001);
    tick();
    check_eq("ret100_idle", st_a, 0);
    check_eq("ret100_total", total_a, 0);

    // plan 1: 500 + 1000 together
    drive_a(3'b110, 4'b0000, 1'b0);
    check_eq("p1_total", total_a, 1500);
    check_eq("p1_avail", avail_a, 4'b0111);
    check_eq("p1_state", st_a, 1);

    // plan 2: buy item2 with a coin alongside
    drive_a(3'b001, 4'b0100, 1'b0);
    check_eq("p2_item", item_a, 4'b0100);
    check_eq("p2_total", total_a, 600);
    tick();
    check_eq("p2_pulse_end", item_a, 0);

    // plan 3: change return from 1600
    drive_a(3'b100, 4'b0000, 1'b0);
    check_eq("p3_total", total_a, 1600);
    exp_q.push_back(3'b100); tot_q.push_back(31'd600);
    exp_q.push_back(3'b010); tot_q.push_back(31'd100);
    exp_q.push_back(3'b001); tot_q.push_back(31'd0);
    drive_a(3'b000, 4'b0010, 1'b1);
    check_eq("p3_no_buy", item_a, 0);
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      check_eq("p3_busy", busy_a, 1);
      check_eq("p3_coin", ret_a, exp_q.pop_front());
      tick();
      check_eq("p3_total_step", total_a, tot_q.pop_front());
    end
    check_eq("p3_left", exp_q.size(), 0);
    check_eq("p3_busy_end", busy_a, 0);
    check_eq("p3_idle", st_a, 0);

    // plan 4: idle timeout
    drive_a(3'b001, 4'b0000, 1'b0);
    for (int k = 0; k < 99; k++) tick();
    check_eq("p4_before", busy_a, 0);
    check_eq("p4_before_st", st_a, 1);
    tick();
    check_eq("p4_busy", busy_a, 1);
    check_eq("p4_coin", ret_a, 3'b001);
    tick();
    check_eq("p4_idle", st_a, 0);
    check_eq("p4_total", total_a, 0);

    // plan 5: 11-bit total, overflow rejection
    drive_b(3'b110, 4'b0000);
    check_eq("p5_total", total_b, 1500);
    check_eq("p5_avail", avail_b, 4'b0111);
    drive_b(3'b000, 4'b1000);
    check_eq("p5_no_item", item_b, 0);
    check_eq("p5_unchanged", total_b, 1500);
    drive_b(3'b010, 4'b0000);
    check_eq("p5_2000", total_b, 2000);
    check_eq("p5_avail_all", avail_b, 4'b1111);
    drive_b(3'b001, 4'b0000);
    check_eq("p5_reject", total_b, 2000);
    drive_b(3'b111, 4'b0000);
    check_eq("p5_reject_all", total_b, 2000);
    drive_b(3'b001, 4'b0001);
    check_eq("p5_buy_item", item_b, 4'b0001);
    check_eq("p5_buy_total", total_b, 1700);

    // plan 6: reset mid-return
    drive_a(3'b111, 4'b0000, 1'b0);
    check_eq("p6_total", total_a, 1600);
    drive_a(3'b000, 4'b0000, 1'b1);
    tick();
    check_eq("p6_mid_total", total_a, 600);
    check_eq("p6_mid_coin", ret_a, 3'b010);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("p6_rst_coin", ret_a, 0);
    check_eq("p6_rst_busy", busy_a, 0);
    check_eq("p6_rst_total", total_a, 0);
    check_eq("p6_rst_item", item_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive_a(3'b010, 4'b0000, 1'b0);
    check_eq("p6_after_total", total_a, 500);
    check_eq("p6_after_state", st_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
